mux_scan_sequencer: RTL and testbench
=====================================

# mux_scan_sequencer

Upstream controller for the 4-to-1 single-bit multiplexer (`Mux4_2`). It drives the mux select lines `control1`/`control2` through all four channels in a fixed order and waits a programmable settle time per channel. It samples the mux output once per channel and presents the four sampled bits as one word on a valid/ready handshake. It turns the combinational mux into a sequential 4-bit snapshot reader of `in1..in4`.

## Interface
- `SETTLE_CYCLES`, default 2: clock cycles each select value is held before the mux output is sampled. Must be ≥ 1; 0 is an elaboration error.
- `clk`  input  1  system clock; all logic is on the rising edge.
- `reset`  input  1  synchronous, active-high reset.
- `start`  input  1  requests one scan; sampled only in IDLE.
- `mux_out`  input  1  connects to the mux `out`.
- `control1`  output  1  mux select MSB.
- `control2`  output  1  mux select LSB.
- `busy`  output  1  high in SETTLE and VALID.
- `data`  output  4  `data[0]`=in1, `data[1]`=in2, `data[2]`=in3, `data[3]`=in4.
- `valid`  output  1  `data` holds a complete scan.
- `ready`  input  1  consumer accepts `data` when `valid && ready`.
- `parity`  output  1  XOR of `data`. Present only with `MUX_SCAN_PARITY_EN`.

## Operation
- Select encoding `{control1,control2}`: 00→in1, 01→in2, 10→in3, 11→in4. Channel index `idx` (2 bits) drives the selects directly.
- FSM states: IDLE, SETTLE, VALID.
- IDLE: `busy`=0, `valid`=0, selects=00.
  - `start`=1 → `idx`=0, settle counter=SETTLE_CYCLES−1, go to SETTLE.
- SETTLE, counter≠0: decrement the counter.
- SETTLE, counter=0: write `mux_out` into `data[idx]`.
  - If `idx`=3 → go to VALID.
  - Otherwise `idx`+1 and reload the counter.
- VALID: `valid`=1. `data`, `parity` and the selects (11) are held stable.
  - `valid && ready` → IDLE.
- `start` is ignored outside IDLE. No queuing; a new request needs `start` high in IDLE.
- `data` bits are overwritten in place during a scan. `data` is meaningful only while `valid`=1.
- `mux_out` is sampled exactly once per channel. Changes on `in*` after a channel is sampled are not reflected in `data`.

## Timing
- Reset values: `control1`=0, `control2`=0, `busy`=0, `data`=4'b0000, `valid`=0, `parity`=0, state IDLE, `idx`=0.
- Edge E0 samples `start`=1. Selects for in1 appear after E0.
- Channel k is sampled on edge E0 + (k+1)·SETTLE_CYCLES, for k=0..3.
- `valid` rises after edge E0 + 4·SETTLE_CYCLES. With the default, that is 8 cycles after the start edge.
- `valid && ready` on edge Ea → `valid`=0 and `busy`=0 after Ea. `start` is accepted on Ea+1 at the earliest.
- `ready` is don't-care outside VALID.
- `ready` held low keeps VALID and all outputs indefinitely.
- Reset asserted in any state, including mid-scan: all outputs take their reset values on the next edge. Any partial word is discarded.
- Reset and `start` in the same cycle: reset wins.

## Configuration
- `MUX_SCAN_PARITY_EN` defined:
  - The `parity` port exists.
  - `parity` is registered, updated on the same edge as the final sample (`data[3]`), and equals ^`data` of the completed word.
  - `parity` is held through VALID and resets to 0.
- `MUX_SCAN_PARITY_EN` undefined: no `parity` port and no parity logic. All other behaviour is identical.

## Structure
- Package `mux_scan_pkg` holds:
  - the state enum (IDLE, SETTLE, VALID);
  - constant `MUX_SCAN_CHANNELS`=4;
  - the select-encoding constants for in1..in4.
- Sub-module `mux_scan_settle_timer`:
  - load/decrement counter sized $clog2(SETTLE_CYCLES) (minimum 1 bit);
  - outputs `expired` when the count is 0.
- The top level holds the FSM, `idx`, the data register and the optional parity register.

## Test plan
- Default SETTLE_CYCLES=2; mux model with in1..in4 = 1,0,1,1; pulse `start`, `ready`=1 → `valid` rises 8 cycles after the start edge, `data`=4'b1101, `parity`=1. Select sequence is 00,01,10,11, each held 2 cycles.
- Same stimulus with `ready`=0 for 5 cycles after `valid` → `data`, `valid` and selects stay constant. Transaction completes on the first `ready`=1 edge, then IDLE.
- Reset pulsed 3 cycles into a scan → next cycle all outputs are 0 and state is IDLE. A fresh `start` with in1..in4 = 0,1,1,0 yields `data`=4'b0110, `parity`=0.
- `start` held high through a scan → exactly one word per IDLE entry. Back-to-back scans are separated by one IDLE cycle.
- SETTLE_CYCLES=1 with in1..in4 = 1,1,1,1 → `valid` 4 cycles after start, `data`=4'b1111. Toggling in1 to 0 after its sample edge leaves `data[0]`=1.
- Build without `MUX_SCAN_PARITY_EN` → the first scenario gives identical `data` and timing, and the netlist has no `parity` port.

Source files
------------

// File: rtl/mux_scan_sequencer_pkg.sv
// rtl/mux_scan_sequencer_pkg.sv - shared types and constants for the mux scan sequencer
// Holds the scan state enum, channel count and select encodings.
package mux_scan_pkg;

  localparam int MUX_SCAN_CHANNELS = 4;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_VALID  = 2'd2
  } scan_state_e;

  // {control1,control2} for each mux input
  localparam logic [1:0] SEL_IN1 = 2'b00;
  localparam logic [1:0] SEL_IN2 = 2'b01;
  localparam logic [1:0] SEL_IN3 = 2'b10;
  localparam logic [1:0] SEL_IN4 = 2'b11;

  function automatic int settle_cnt_width(input int cycles);
    return (cycles > 1) ? $clog2(cycles) : 1;
  endfunction

endpackage

// File: rtl/mux_scan_sequencer_if.sv
// rtl/mux_scan_sequencer_if.sv - scan result handshake bundle (parity under MUX_SCAN_PARITY_EN)
// Master is the sequencer presenting data/valid; slave is the consumer driving ready.
interface mux_scan_sequencer_if;
  logic [3:0] data;
  logic       valid;
  logic       ready;
`ifdef MUX_SCAN_PARITY_EN
  logic       parity;

  modport master (output data, output valid, output parity, input ready);
  modport slave  (input data, input valid, input parity, output ready);
`else
  modport master (output data, output valid, input ready);
  modport slave  (input data, input valid, output ready);
`endif
endinterface

// File: rtl/mux_scan_settle_timer.sv
// rtl/mux_scan_settle_timer.sv - load/decrement settle counter for the mux scan sequencer
// expired_o is high whenever the count has reached zero.
module mux_scan_settle_timer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic load_i,
  input  logic dec_i,
  output logic expired_o
);

  localparam int W = settle_cnt_width(SETTLE_CYCLES);
  localparam logic [W-1:0] LOAD_VAL = W'(SETTLE_CYCLES - 1);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i) begin
      cnt_d = LOAD_VAL;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_d = cnt_q - W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/mux_scan_sequencer.sv
// rtl/mux_scan_sequencer.sv - steps a 4:1 mux through its inputs and returns a 4-bit snapshot
// Optional registered parity of the word when MUX_SCAN_PARITY_EN is defined.
module mux_scan_sequencer
  import mux_scan_pkg::*;
#(
  parameter int SETTLE_CYCLES = 2
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        start,
  input  logic                        mux_out,
  output logic                        control1,
  output logic                        control2,
  output logic                        busy,
  mux_scan_sequencer_if.master        out_if
);

  if (SETTLE_CYCLES < 1) begin : g_bad_settle
    $error("mux_scan_sequencer: SETTLE_CYCLES must be >= 1");
  end

  localparam logic [1:0] LAST_IDX = 2'(MUX_SCAN_CHANNELS - 1);

  scan_state_e state_q;
  logic [1:0]  idx_q;
  logic [3:0]  data_q;
  logic        valid_q;
  logic        busy_q;
  logic        expired;
  logic        tmr_load;
  logic        tmr_dec;

  // Reload on scan start and on every channel change except the last.
  assign tmr_load = ((state_q == ST_IDLE) && start) ||
                    ((state_q == ST_SETTLE) && expired && (idx_q != LAST_IDX));
  assign tmr_dec  = (state_q == ST_SETTLE);

  mux_scan_settle_timer #(
    .SETTLE_CYCLES (SETTLE_CYCLES)
  ) u_settle_timer (
    .clk       (clk),
    .reset     (reset),
    .load_i    (tmr_load),
    .dec_i     (tmr_dec),
    .expired_o (expired)
  );

`ifdef MUX_SCAN_PARITY_EN
  logic parity_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      parity_q <= 1'b0;
    end else if ((state_q == ST_SETTLE) && expired && (idx_q == LAST_IDX)) begin
      parity_q <= ^{mux_out, data_q[2:0]};
    end
  end

  assign out_if.parity = parity_q;
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      idx_q   <= SEL_IN1;
      data_q  <= 4'b0000;
      valid_q <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (start) begin
            state_q <= ST_SETTLE;
            idx_q   <= SEL_IN1;
            busy_q  <= 1'b1;
          end
        end
        ST_SETTLE: begin
          if (expired) begin
            data_q[idx_q] <= mux_out;
            if (idx_q == LAST_IDX) begin
              state_q <= ST_VALID;
              valid_q <= 1'b1;
            end else begin
              idx_q <= idx_q + 2'd1;
            end
          end
        end
        ST_VALID: begin
          if (out_if.ready) begin
            state_q <= ST_IDLE;
            idx_q   <= SEL_IN1;
            valid_q <= 1'b0;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= SEL_IN1;
          valid_q <= 1'b0;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  // The channel index doubles as the mux select; it sits at 00 in IDLE.
  assign control1     = idx_q[1];
  assign control2     = idx_q[0];
  assign busy         = busy_q;
  assign out_if.data  = data_q;
  assign out_if.valid = valid_q;

endmodule

// File: tb/tb_mux_scan_sequencer.sv
// tb/tb_mux_scan_sequencer.sv - scoreboard bench for mux_scan_sequencer (parity checks under MUX_SCAN_PARITY_EN)
module tb_mux_scan_sequencer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start_a, start_b;
  logic       c1a, c2a, busy_a, c1b, c2b, busy_b;
  logic [3:0] in_a, in_b;
  logic       mux_a, mux_b;

  int total = 0;
  int bad   = 0;
  logic [3:0] exp_q[$];

  mux_scan_sequencer_if if_a ();
  mux_scan_sequencer_if if_b ();

  assign mux_a = in_a[{c1a, c2a}];
  assign mux_b = in_b[{c1b, c2b}];

  mux_scan_sequencer #(.SETTLE_CYCLES(2)) dut_a (
    .clk      (clk),
    .reset    (reset),
    .start    (start_a),
    .mux_out  (mux_a),
    .control1 (c1a),
    .control2 (c2a),
    .busy     (busy_a),
    .out_if   (if_a.master)
  );

  mux_scan_sequencer #(.SETTLE_CYCLES(1)) dut_b (
    .clk      (clk),
    .reset    (reset),
    .start    (start_b),
    .mux_out  (mux_b),
    .control1 (c1b),
    .control2 (c2b),
    .busy     (busy_b),
    .out_if   (if_b.master)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle_a(input string tag);
    check({tag, "_valid"}, if_a.valid, 0);
    check({tag, "_busy"}, busy_a, 0);
    check({tag, "_sel"}, {c1a, c2a}, 0);
  endtask

  // One scan on dut_a; ready held low for `hold` cycles after valid rises.
  task automatic scan_a(input logic [3:0] word, input int hold);
    int n;
    logic [3:0] w;
    @(negedge clk);
    in_a = word;
    start_a = 1'b1;
    if_a.ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(word);
    @(negedge clk);
    start_a = 1'b0;
    n = 0;
    while (!if_a.valid && n < 40) begin
      if (n < 8) check("sel_seq", {c1a, c2a}, n / 2);
      check("busy_scan", busy_a, 1);
      @(negedge clk);
      n++;
    end
    check("valid_lat", n, 8);
    repeat (hold) begin
      check("hold_valid", if_a.valid, 1);
      check("hold_data", if_a.data, word);
      check("hold_sel", {c1a, c2a}, 3);
      check("hold_busy", busy_a, 1);
      @(negedge clk);
    end
    if_a.ready = 1'b1;
    check("valid_hi", if_a.valid, 1);
    if (exp_q.size() == 0) begin
      check("sb_underflow", 1, 0);
    end else begin
      w = exp_q.pop_front();
      check("data", if_a.data, w);
`ifdef MUX_SCAN_PARITY_EN
      check("parity", if_a.parity, ^w);
`endif
    end
    @(negedge clk);
    check_idle_a("post_accept");
    if_a.ready = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    int words;
    int exp_at[$];
    logic [3:0] w;

    reset = 1'b1;
    start_a = 1'b0;
    start_b = 1'b0;
    in_a = 4'b0000;
    in_b = 4'b0000;
    if_a.ready = 1'b0;
    if_b.ready = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_idle_a("reset");
    check("reset_data", if_a.data, 0);
`ifdef MUX_SCAN_PARITY_EN
    check("reset_parity", if_a.parity, 0);
`endif
    reset = 1'b0;

    // in1..in4 = 1,0,1,1
    scan_a(4'b1101, 0);
    scan_a(4'b1101, 5);

    // Reset mid-scan discards the partial word.
    @(negedge clk);
    in_a = 4'b1111;
    start_a = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start_a = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check_idle_a("midreset");
    check("midreset_data", if_a.data, 0);
    scan_a(4'b0110, 0);

    // start held high: one word per IDLE entry, one IDLE cycle between scans.
    @(negedge clk);
    in_a = 4'b1010;
    start_a = 1'b1;
    if_a.ready = 1'b1;
    @(posedge clk);
    repeat (3) exp_q.push_back(4'b1010);
    exp_at = '{8, 18, 28};
    words = 0;
    for (n = 0; n <= 32; n++) begin
      @(negedge clk);
      if (n == 20) start_a = 1'b0;
      if (n == 9 || n == 19) check("bb_gap_busy", busy_a, 0);
      if (n == 10) check("bb_restart_busy", busy_a, 1);
      if (if_a.valid) begin
        words++;
        if (exp_at.size() == 0 || exp_q.size() == 0) begin
          check("bb_extra_word", n, 0);
        end else begin
          check("bb_valid_at", n, exp_at.pop_front());
          w = exp_q.pop_front();
          check("bb_data", if_a.data, w);
        end
      end
    end
    check("bb_words", words, 3);
    check_idle_a("bb_end");
    if_a.ready = 1'b0;

    // SETTLE_CYCLES=1: late change on in1 is not captured.
    @(negedge clk);
    in_b = 4'b1111;
    start_b = 1'b1;
    if_b.ready = 1'b0;
    @(posedge clk);
    exp_q.push_back(4'b1111);
    @(negedge clk);
    start_b = 1'b0;
    n = 0;
    while (!if_b.valid && n < 40) begin
      if (n == 1) in_b[0] = 1'b0;
      if (n < 4) check("s1_sel", {c1b, c2b}, n);
      @(negedge clk);
      n++;
    end
    check("s1_lat", n, 4);
    if_b.ready = 1'b1;
    if (exp_q.size() == 0) begin
      check("s1_underflow", 1, 0);
    end else begin
      w = exp_q.pop_front();
      check("s1_data", if_b.data, w);
`ifdef MUX_SCAN_PARITY_EN
      check("s1_parity", if_b.parity, ^w);
`endif
    end
    @(negedge clk);
    check("s1_post_valid", if_b.valid, 0);
    check("s1_post_busy", busy_b, 0);
    check("sb_drained", exp_q.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
